crc_stream_engine: RTL and testbench

Streaming, parametrised parallel CRC engine. It accepts a frame of DWIDTH-bit words over a valid/ready handshake and folds CALWIDTH bits per clock into a CRC_WIDTH-bit remainder. It presents the finalised CRC over a second valid/ready handshake. Polynomial, initial value, bit reflection and final XOR are runtime-configurable, so the same engine covers CRC-8, CRC-16 and CRC-32 variants in the datapath checkers.

---
 rtl/crc_pkg.sv | 45 ++++
 rtl/crc_stream_engine_if.sv | 23 ++
 rtl/crc_chunk_step.sv | 26 ++
 rtl/crc_stream_engine.sv | 127 ++++++++++++
 tb/tb_crc_stream_engine.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC engine: FSM state encoding,
// bit-reversal helpers and a clog2 that never returns less than 1.
package crc_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } stateT;

    // Widest vector the reversal helpers handle; callers cast in and out.
    localparam int MAX_WIDTH = 64;

    function automatic int clog2Min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Reverse bit order inside every byte of the low `width` bits.
    function automatic logic [MAX_WIDTH-1:0] byteReflect(input logic [MAX_WIDTH-1:0] v,
                                                         input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) r[(i & ~7) | (7 - (i & 7))] = v[i];
        end
        return r;
    endfunction

    // Reverse the full low `width` bits end to end.
    function automatic logic [MAX_WIDTH-1:0] bitReverse(input logic [MAX_WIDTH-1:0] v,
                                                        input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) r[width - 1 - i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Word-in / CRC-out handshake bundle of the streaming CRC engine.
interface crc_stream_engine_if #(
    parameter int DWIDTH    = 32,
    parameter int CRC_WIDTH = 8
);
    logic                 inValid;
    logic                 inReady;
    logic [DWIDTH-1:0]    inData;
    logic                 inLast;
    logic                 outValid;
    logic                 outReady;
    logic [CRC_WIDTH-1:0] crcOut;

    modport master (
        output inValid, inData, inLast, outReady,
        input  inReady, outValid, crcOut
    );

    modport slave (
        input  inValid, inData, inLast, outReady,
        output inReady, outValid, crcOut
    );
endinterface

// File: rtl/crc_chunk_step.sv
// Combinational fold of one CALWIDTH-bit chunk into the CRC remainder,
// MSB of the chunk first.
module crc_chunk_step #(
    parameter int CRC_WIDTH = 8,
    parameter int CALWIDTH  = 8
) (
    input  logic [CRC_WIDTH-1:0] rem,
    input  logic [CALWIDTH-1:0]  chunk,
    input  logic [CRC_WIDTH-1:0] poly,
    output logic [CRC_WIDTH-1:0] nextRem
);
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;

    always_comb begin
        // NOTE: blocking assignments here chain each bit's result into the
        // next iteration, unrolling into one XOR network per chunk.
        r  = rem;
        fb = 1'b0;
        for (int i = CALWIDTH - 1; i >= 0; i--) begin
            fb = r[CRC_WIDTH-1] ^ chunk[i];
            r  = (r << 1) ^ (fb ? poly : '0);
        end
        nextRem = r;
    end
endmodule

// File: rtl/crc_stream_engine.sv
// Streaming parallel CRC engine: accepts DWIDTH-bit words, folds CALWIDTH
// bits per cycle and presents the finalised CRC over an output handshake.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int CRC_WIDTH = 8,
    parameter int DWIDTH    = 32,
    parameter int CALWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 cfgEn,
    input  logic [CRC_WIDTH-1:0] cfgPoly,
    input  logic [CRC_WIDTH-1:0] cfgInit,
    input  logic [CRC_WIDTH-1:0] cfgXorOut,
    input  logic                 cfgReflectIn,
    input  logic                 cfgReflectOut,
    crc_stream_engine_if.slave   bus
);
    localparam int CALNUM   = DWIDTH / CALWIDTH;
    localparam int COUNTERW = clog2Min1(CALNUM);
    localparam logic [COUNTERW-1:0] LAST_CHUNK = COUNTERW'(CALNUM - 1);

    stateT                state, nextState;
    logic                 firstWord;
    logic [CRC_WIDTH-1:0] rem, polyReg, initReg, xorReg;
    logic                 reflInReg, reflOutReg;
    logic [DWIDTH-1:0]    shiftReg;
    logic                 lastReg;
    logic [COUNTERW-1:0]  count;

    logic                 inAcc, accept, cfgApply, lastChunk, effReflIn;
    logic [CRC_WIDTH-1:0] effInit, stepRem, finalRem;
    logic [DWIDTH-1:0]    acceptData;

    assign inAcc     = (state == ACC);
    assign accept    = inAcc && bus.inValid;
    assign cfgApply  = inAcc && firstWord && cfgEn;
    assign lastChunk = (count == LAST_CHUNK);

    // A config load coinciding with the first word governs that same frame.
    assign effInit    = cfgApply ? cfgInit : initReg;
    assign effReflIn  = cfgApply ? cfgReflectIn : reflInReg;
    assign acceptData = effReflIn ? DWIDTH'(byteReflect(MAX_WIDTH'(bus.inData), DWIDTH))
                                  : bus.inData;

    crc_chunk_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .CALWIDTH  (CALWIDTH)
    ) uStep (
        .rem     (rem),
        .chunk   (shiftReg[DWIDTH-1 -: CALWIDTH]),
        .poly    (polyReg),
        .nextRem (stepRem)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!rstN) state <= ACC;
        else       state <= nextState;
    end

    always_comb begin
        // NOTE: default first so every path assigns nextState and no latch
        // is inferred.
        nextState = state;
        unique case (state)
            ACC:     if (accept)       nextState = SHIFT;
            SHIFT:   if (lastChunk)    nextState = lastReg ? HOLD : ACC;
            HOLD:    if (bus.outReady) nextState = ACC;
            default:                   nextState = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            firstWord  <= 1'b1;
            rem        <= '0;
            polyReg    <= '0;
            initReg    <= '0;
            xorReg     <= '0;
            reflInReg  <= 1'b0;
            reflOutReg <= 1'b0;
            count      <= '0;
        end else begin
            if (cfgApply) begin
                polyReg    <= cfgPoly;
                initReg    <= cfgInit;
                xorReg     <= cfgXorOut;
                reflInReg  <= cfgReflectIn;
                reflOutReg <= cfgReflectOut;
            end
            unique case (state)
                ACC: if (accept) begin
                    count     <= '0;
                    firstWord <= 1'b0;
                    if (firstWord) rem <= effInit;
                end
                SHIFT: begin
                    rem   <= stepRem;
                    count <= lastChunk ? '0 : count + 1'b1;
                end
                HOLD: if (bus.outReady) firstWord <= 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; the FSM never reads them
    // before they are loaded by an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            shiftReg <= acceptData;
            lastReg  <= bus.inLast;
        end else if (state == SHIFT) begin
            shiftReg <= shiftReg << CALWIDTH;
        end
    end

    assign finalRem = (reflOutReg ? CRC_WIDTH'(bitReverse(MAX_WIDTH'(rem), CRC_WIDTH)) : rem)
                      ^ xorReg;

    assign bus.inReady  = inAcc;
    assign bus.outValid = (state == HOLD);
    assign bus.crcOut   = (state == HOLD) ? finalRem : '0;
endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench: four engine instances (default, CRC-8, CRC-16/CAL4,
// CRC-32 on byte buses) against catalogue vectors and a message-level model.
module tb_crc_stream_engine;

    localparam int NI = 4;
    // Per-instance parameters, index 0 = default parameters.
    localparam logic [NI-1:0][7:0] CRCW = {8'd32, 8'd16, 8'd8, 8'd8};
    localparam logic [NI-1:0][7:0] DW   = {8'd8,  8'd8,  8'd8, 8'd32};
    localparam logic [NI-1:0][7:0] CW   = {8'd8,  8'd4,  8'd8, 8'd8};

    typedef byte unsigned bytesT[$];

    typedef struct {
        int          k;
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xo;
        bit          ri;
        bit          ro;
        logic [31:0] expected;
    } vecT;

    logic clk = 1'b0;
    logic rstN;
    int   cyc = 0;

    logic        cfgEnV[NI];
    logic [31:0] polyV[NI], initV[NI], xorV[NI];
    logic        riV[NI], roV[NI];
    logic        validV[NI], lastV[NI], outReadyV[NI];
    logic [31:0] dataV[NI];
    logic        readyV[NI], outValidV[NI];
    logic [31:0] crcV[NI];

    int nCompared = 0;
    int nMismatch = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : gInst
        localparam int GW = int'(CRCW[g]);
        localparam int GD = int'(DW[g]);
        localparam int GC = int'(CW[g]);

        crc_stream_engine_if #(.DWIDTH(GD), .CRC_WIDTH(GW)) bus ();

        assign bus.inValid  = validV[g];
        assign bus.inData   = GD'(dataV[g]);
        assign bus.inLast   = lastV[g];
        assign bus.outReady = outReadyV[g];
        assign readyV[g]    = bus.inReady;
        assign outValidV[g] = bus.outValid;
        assign crcV[g]      = 32'(bus.crcOut);

        crc_stream_engine #(.CRC_WIDTH(GW), .DWIDTH(GD), .CALWIDTH(GC)) dut (
            .clk           (clk),
            .rstN          (rstN),
            .cfgEn         (cfgEnV[g]),
            .cfgPoly       (GW'(polyV[g])),
            .cfgInit       (GW'(initV[g])),
            .cfgXorOut     (GW'(xorV[g])),
            .cfgReflectIn  (riV[g]),
            .cfgReflectOut (roV[g]),
            .bus           (bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Message-level CRC: bitwise long division of the whole byte stream.
    function automatic logic [31:0] crcModel(input bytesT msg, input int w,
                                             input logic [31:0] poly, input logic [31:0] init,
                                             input logic [31:0] xo, input bit ri, input bit ro);
        longint unsigned mask, rem, refl, p;
        byte unsigned    b, rb;
        mask = (64'd1 << w) - 1;
        p    = 64'(poly) & mask;
        rem  = 64'(init) & mask;
        foreach (msg[i]) begin
            b  = msg[i];
            rb = b;
            if (ri) for (int j = 0; j < 8; j++) rb[7 - j] = b[j];
            for (int j = 7; j >= 0; j--) begin
                bit fb;
                fb  = rem[w - 1] ^ rb[j];
                rem = ((rem << 1) & mask) ^ (fb ? p : 64'd0);
            end
        end
        if (ro) begin
            refl = 0;
            for (int j = 0; j < w; j++) refl[w - 1 - j] = rem[j];
            rem = refl;
        end
        rem = (rem ^ 64'(xo)) & mask;
        return rem[31:0];
    endfunction

    task automatic setCfg(input int k, input logic [31:0] p, input logic [31:0] i,
                          input logic [31:0] x, input bit ri, input bit ro);
        polyV[k] = p; initV[k] = i; xorV[k] = x; riV[k] = ri; roV[k] = ro;
    endtask

    task automatic applyCfg(input int k);
        cfgEnV[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfgEnV[k] = 1'b0;
    endtask

    // Called and returns just after a falling edge.
    task automatic sendFrame(input int k, input bytesT msg, input bit cfgWithFirst,
                             input int gapMax, output int acceptCyc);
        int bpw, nWords;
        logic [31:0] word;
        bpw    = int'(DW[k]) / 8;
        nWords = msg.size() / bpw;
        acceptCyc = cyc;
        for (int wi = 0; wi < nWords; wi++) begin
            int t;
            word = '0;
            for (int b = 0; b < bpw; b++) word = (word << 8) | 32'(msg[wi * bpw + b]);
            repeat ($urandom_range(gapMax)) @(negedge clk);
            dataV[k]  = word;
            lastV[k]  = (wi == nWords - 1);
            validV[k] = 1'b1;
            if (cfgWithFirst && wi == 0) cfgEnV[k] = 1'b1;
            t = 0;
            while (!readyV[k] && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!readyV[k]) check("inReady wait", 32'(readyV[k]), 32'd1);
            @(posedge clk);
            @(negedge clk);
            validV[k] = 1'b0;
            lastV[k]  = 1'b0;
            if (cfgWithFirst) cfgEnV[k] = 1'b0;
            acceptCyc = cyc;
        end
    endtask

    task automatic waitOutValid(input int k, input int acceptCyc, output int lat);
        int t;
        t = 0;
        while (!outValidV[k] && t < 500) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - acceptCyc + 1;
        if (!outValidV[k]) check("outValid wait", 32'(outValidV[k]), 32'd1);
    endtask

    task automatic getResult(input int k, input int holdCycles, input int acceptCyc,
                             output logic [31:0] v, output int lat);
        waitOutValid(k, acceptCyc, lat);
        repeat (holdCycles) @(negedge clk);
        v = crcV[k];
        outReadyV[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReadyV[k] = 1'b0;
    endtask

    bytesT check9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecT         vecs[8];
        bytesT       msg;
        logic [31:0] v, expv;
        int          acc, lat;

        for (int k = 0; k < NI; k++) begin
            cfgEnV[k] = 0; validV[k] = 0; lastV[k] = 0; outReadyV[k] = 0; dataV[k] = '0;
            setCfg(k, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        rstN = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset inReady[%0d]", k),  32'(readyV[k]),    32'd1);
            check($sformatf("reset outValid[%0d]", k), 32'(outValidV[k]), 32'd0);
            check($sformatf("reset crcOut[%0d]", k),   crcV[k],           32'd0);
        end
        rstN = 1'b1;
        @(negedge clk);

        // Catalogue check values over "123456789".
        vecs[0] = '{1, 32'h07,       32'h0,        32'h0,        1'b0, 1'b0, 32'hF4};
        vecs[1] = '{1, 32'h31,       32'h0,        32'h0,        1'b1, 1'b1, 32'hA1};
        vecs[2] = '{2, 32'h1021,     32'hFFFF,     32'h0,        1'b0, 1'b0, 32'h29B1};
        vecs[3] = '{2, 32'h1021,     32'h0,        32'h0,        1'b0, 1'b0, 32'h31C3};
        vecs[4] = '{2, 32'h8005,     32'h0,        32'h0,        1'b1, 1'b1, 32'hBB3D};
        vecs[5] = '{3, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hCBF43926};
        vecs[6] = '{3, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFC891918};
        vecs[7] = '{3, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 32'h0376E6E7};
        foreach (vecs[i]) begin
            setCfg(vecs[i].k, vecs[i].poly, vecs[i].init, vecs[i].xo, vecs[i].ri, vecs[i].ro);
            applyCfg(vecs[i].k);
            sendFrame(vecs[i].k, check9, 1'b0, 1, acc);
            getResult(vecs[i].k, 0, acc, v, lat);
            check($sformatf("vector %0d crc", i), v, vecs[i].expected);
            check($sformatf("vector %0d latency", i), 32'(lat),
                  32'(int'(DW[vecs[i].k]) / int'(CW[vecs[i].k]) + 1));
        end

        // Default parameters: latency and back-pressure.
        setCfg(0, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
        applyCfg(0);
        msg  = '{8'h01, 8'h00, 8'h00, 8'h00};
        expv = crcModel(msg, 8, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
        sendFrame(0, msg, 1'b0, 0, acc);
        waitOutValid(0, acc, lat);
        check("bp latency", 32'(lat), 32'd5);
        for (int c = 0; c < 10; c++) begin
            check("bp crcOut", crcV[0], expv);
            check("bp inReady", 32'(readyV[0]), 32'd0);
            check("bp outValid", 32'(outValidV[0]), 32'd1);
            @(negedge clk);
        end
        outReadyV[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReadyV[0] = 1'b0;
        check("post-accept inReady", 32'(readyV[0]), 32'd1);
        check("post-accept outValid", 32'(outValidV[0]), 32'd0);

        // cfgEn during SHIFT is ignored.
        msg = {};
        for (int j = 0; j < 8; j++) msg.push_back(8'($urandom));
        expv = crcModel(msg, 8, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
        fork
            sendFrame(0, msg, 1'b0, 0, acc);
            begin
                @(posedge clk);
                @(negedge clk);
                polyV[0]  = 32'h31;
                cfgEnV[0] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                cfgEnV[0] = 1'b0;
            end
        join
        getResult(0, 0, acc, v, lat);
        check("cfgEn in SHIFT ignored", v, expv);

        // cfgEn together with the first word governs that frame.
        setCfg(0, 32'h31, 32'hA5, 32'h0F, 1'b1, 1'b0);
        msg = {};
        for (int j = 0; j < 8; j++) msg.push_back(8'($urandom));
        expv = crcModel(msg, 8, 32'h31, 32'hA5, 32'h0F, 1'b1, 1'b0);
        sendFrame(0, msg, 1'b1, 0, acc);
        getResult(0, 0, acc, v, lat);
        check("cfgEn with first word", v, expv);

        // Reset mid-frame discards frame and configuration.
        dataV[0]  = $urandom;
        lastV[0]  = 1'b0;
        validV[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validV[0] = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        check("mid reset inReady", 32'(readyV[0]), 32'd1);
        check("mid reset outValid", 32'(outValidV[0]), 32'd0);
        check("mid reset crcOut", crcV[0], 32'd0);
        msg = {};
        for (int j = 0; j < 4; j++) msg.push_back(8'($urandom));
        expv = crcModel(msg, 8, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        sendFrame(0, msg, 1'b0, 0, acc);
        getResult(0, 0, acc, v, lat);
        check("post reset cfg cleared", v, expv);

        // Randomised frames against the model.
        for (int n = 0; n < 60; n++) begin
            int k, nWords, bpw;
            bit withFirst;
            k         = $urandom_range(NI - 1);
            bpw       = int'(DW[k]) / 8;
            nWords    = $urandom_range(4, 1);
            withFirst = 1'($urandom);
            setCfg(k, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
            msg = {};
            for (int j = 0; j < nWords * bpw; j++) msg.push_back(8'($urandom));
            expv = crcModel(msg, int'(CRCW[k]), polyV[k], initV[k], xorV[k], riV[k], roV[k]);
            if (!withFirst) applyCfg(k);
            sendFrame(k, msg, withFirst, 2, acc);
            getResult(k, $urandom_range(3), acc, v, lat);
            check($sformatf("random %0d inst %0d", n, k), v, expv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
